// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits a debounced hex key code.
// Define KEY_REPEAT_EN to re-pulse key_valid every REPEAT_SAMPLES samples while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_CNT   = 4,
    parameter int REPEAT_SAMPLES = 64
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    // nibble {r,c} holds the legend of the key at row r, column c
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        r_state, w_state;
    logic [3:0]    r_sync1, r_rs, r_col, r_pat, r_key;
    logic [3:0]    w_col, w_pat, w_key, w_low;
    logic [DW-1:0] r_dwell;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [1:0]    w_r, w_c;
    logic          r_valid, r_held, w_valid, w_held, w_sample, w_one, w_accept;
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    logic [RW-1:0] r_rep, w_rep;
`endif

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_valid;
    assign key_held  = r_held;

    assign w_sample = r_dwell == DW'(SCAN_DIV - 1);
    assign w_low    = ~r_rs;
    assign w_one    = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_r      = {w_low[3] | w_low[2], w_low[3] | w_low[1]};
    assign w_c      = {~r_col[3] | ~r_col[2], ~r_col[3] | ~r_col[1]};
    // r_rs matching the one-low capture means row/column are still the captured ones
    assign w_accept = w_sample && ((r_state == SCAN && w_one && DEBOUNCE_CNT == 1) ||
                      (r_state == DEBOUNCE && r_rs == r_pat && r_cnt == CW'(DEBOUNCE_CNT - 1)));

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_col   = r_col;
        w_pat   = r_pat;
        w_key   = r_key;
        w_valid = 1'b0;
        w_held  = r_held;
`ifdef KEY_REPEAT_EN
        w_rep   = r_rep;
`endif
        if (w_sample) begin
            case (r_state)
                SCAN: begin
                    if (w_one) begin
                        w_pat   = r_rs;
                        w_cnt   = CW'(1);
                        w_state = DEBOUNCE;
                    end else
                        w_col = {r_col[2:0], r_col[3]};
                end
                DEBOUNCE: begin
                    w_cnt = r_cnt + 1'b1;
                    if (r_rs != r_pat) begin
                        w_state = SCAN;
                        w_cnt   = '0;
                    end
                end
                default: begin
                    w_cnt = &r_rs ? r_cnt + 1'b1 : '0;
                    if (&r_rs && r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
                        w_state = SCAN;
                        w_held  = 1'b0;
                        w_cnt   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    w_rep = &r_rs ? '0 : r_rep + 1'b1;
                    if (!(&r_rs) && r_rep == RW'(REPEAT_SAMPLES - 1)) begin
                        w_rep   = '0;
                        w_valid = 1'b1;
                    end
`endif
                end
            endcase
            if (w_accept) begin
                w_key   = KEYMAP[{w_r, w_c, 2'b00} +: 4];
                w_valid = 1'b1;
                w_held  = 1'b1;
                w_state = HELD;
                w_cnt   = '0;
`ifdef KEY_REPEAT_EN
                w_rep   = '0;
`endif
            end
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_rs    <= 4'hF;
            r_dwell <= '0;
            r_state <= SCAN;
            r_cnt   <= '0;
            r_col   <= 4'b1110;
            r_pat   <= 4'hF;
            r_key   <= 4'h0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_sync1 <= row;
            r_rs    <= r_sync1;
            r_dwell <= w_sample ? '0 : r_dwell + 1'b1;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_col   <= w_col;
            r_pat   <= w_pat;
            r_key   <= w_key;
            r_valid <= w_valid;
            r_held  <= w_held;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset)
            r_rep <= '0;
        else
            r_rep <= w_rep;
    end
`endif
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the seven-segment output path: scans a 4x4 matrix keypad and produces a debounced 4-bit hex key code.
- Its `key` output drives the seven-segment decoder in place of the DIP switches.
- Clocked from the internal low-speed oscillator and instantiated in the lab top level.

Parameters:
- SCAN_DIV, 16: clock cycles each column is driven before its rows are sampled (dwell); minimum 4.
- DEBOUNCE_CNT, 4: consecutive identical samples needed to accept a press or a release; minimum 1.
- REPEAT_SAMPLES, 64: samples between auto-repeat pulses (used only with KEY_REPEAT_EN).

Ports:
- int_osc  input  1  clock, single clock domain.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows; active-low (pulled up externally); asynchronous to int_osc.
- col  output  4  keypad columns; active-low, exactly one bit low at any time.
- key  output  4  hex code of last accepted key; held until the next accepted key.
- key_valid  output  1  one-cycle pulse when `key` is updated.
- key_held  output  1  high while an accepted key remains pressed.

Behaviour:
- Reset (asynchronous, reset=0):
  - col=4'b1110, key=4'h0, key_valid=0, key_held=0.
  - State SCAN; dwell, debounce and repeat counters cleared; synchronizer flops set to 4'hF.
- Row input: 2-flop synchronizer on `row`; all decisions use the synchronized value rs.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps. The sample point is the cycle where the count equals SCAN_DIV-1. rs is evaluated only at sample points.
- Column index c (0..3): col = ~(1<<c).
- Column advance: c advances (3 wraps to 0) at a sample point only in SCAN state when no key is detected. In all other states c is frozen.
- Key map, keyed by (row r, col c) and reading c=0..3 in each row:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN:
  - rs has exactly one bit low at a sample: capture r and c, set debounce count=1, go to DEBOUNCE. If DEBOUNCE_CNT=1, go directly to the accept action.
  - rs all high, or two or more bits low: no capture; column advances.
- DEBOUNCE, at each sample:
  - rs equals the captured pattern: count+1.
  - count reaches DEBOUNCE_CNT: accept. Load `key` from the map, pulse key_valid on the next cycle, set key_held=1, go to HELD, clear the count.
  - Any other rs value: return to SCAN with no output change; column resumes advancing from c.
- HELD, at each sample:
  - rs all high: count+1. When count reaches DEBOUNCE_CNT, go to SCAN and clear key_held on the next cycle.
  - Any low bit in rs: count cleared.
  - Other keys in the frozen column, and all keys in other columns, are ignored. `key` never changes in HELD.
- Latency: key_valid rises 1 cycle after the sample that completes the debounce count. Measured from the first detecting sample, that is (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles; add 2 cycles of synchronizer delay from the pin.
- Outputs: key_valid, key_held and col are registered; no combinational path from row to any output.
- Reset mid-operation: immediate return to reset values; a pending press is discarded, with no valid pulse.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments at each sample where the key is still low.
  - Every REPEAT_SAMPLES such samples it re-pulses key_valid for one cycle with the same `key`.
  - The counter clears on entry to HELD and on any release sample.
- Undefined: exactly one key_valid pulse per accepted press; the repeat counter is not built.

Test Plan (defaults, SCAN_DIV=16, DEBOUNCE_CNT=4):
- Reset sequence:
  - Stimulus: assert reset with row=4'hF, then release.
  - Response: col=1110, key=0, key_valid=0, key_held=0. col then steps 1110→1101→1011→0111→1110, every 16 cycles.
- Clean press:
  - Stimulus: pull row[1] low only while col=1101 (key '5').
  - Response: exactly one key_valid pulse; key=4'h5; key_held=1; col frozen at 1101.
  - Release: key_held falls after 4 all-high samples; key stays 5; scanning resumes.
- Bounce:
  - Stimulus: row[3] toggles at each sample under col=0111.
  - Response: no key_valid, key unchanged. Then hold it stable for 4 samples → key=4'hD with one pulse.
- Multi-key:
  - Stimulus: row[0] and row[2] low together under col=1110.
  - Response: ignored, no pulse, column keeps advancing.
- Held rejection:
  - Stimulus: while '5' is held, press '9' (row2, col2).
  - Response: no pulse; key stays 5.
- Reset mid-debounce:
  - Stimulus: assert reset after 2 matching samples.
  - Response: outputs return to reset values, no pulse.
- KEY_REPEAT_EN, when defined:
  - Stimulus: hold '1'.
  - Response: initial pulse, then a pulse every 64*16 cycles with key=4'h1.
